// File: rtl/wb_commit_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_commit_buffer: in-order writeback buffer with single-entry retirement,  |
// | head interrupt check, trap redirect/flush and youngest-first forwarding.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wb_commit_buffer #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 4,
  parameter int XLEN   = 64,
  parameter int NCAUSE = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES-1:0]          in_valid,
  output logic                      in_ready,
  input  logic [LANES*XLEN-1:0]     in_pc,
  input  logic [LANES*5-1:0]        in_rd,
  input  logic [LANES-1:0]          in_wen,
  input  logic [LANES*XLEN-1:0]     in_data,
  input  logic [LANES-1:0]          in_skip,
  input  logic [1:0]                priviledge_mode,
  input  logic [XLEN-1:0]           mstatus,
  input  logic [XLEN-1:0]           mip,
  input  logic [XLEN-1:0]           mie,
  input  logic [XLEN-1:0]           mtvec,
  output logic                      commit_valid,
  input  logic                      commit_ready,
  output logic [XLEN-1:0]           commit_pc,
  output logic [4:0]                commit_rd,
  output logic                      commit_wen,
  output logic [XLEN-1:0]           commit_data,
  output logic                      commit_skip,
  output logic                      trap_taken,
  output logic [4:0]                trap_cause,
  output logic                      redirect_valid,
  output logic [XLEN-1:0]           redirect_pc,
  input  logic [4:0]                fwd_rd,
  output logic                      fwd_hit,
  output logic [XLEN-1:0]           fwd_data,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;

  logic [XLEN-1:0]  r_pc   [DEPTH];
  logic [XLEN-1:0]  r_data [DEPTH];
  logic [4:0]       r_rd   [DEPTH];
  logic [DEPTH-1:0] r_wen;
  logic [DEPTH-1:0] r_skip;
  logic [DEPTH-1:0] r_vld;
  logic [c_PW-1:0]  r_head;
  logic [c_PW-1:0]  r_tail;
  logic [c_CW-1:0]  r_count;

  logic [c_CW-1:0]  w_n;
  logic [c_PW-1:0]  w_slot [LANES];
  logic             w_enq;
  logic             w_deq;
  logic             w_flush;
  logic [31:0]      w_pend;
  logic [4:0]       w_cause;
  logic             w_gie;
  logic [XLEN-1:0]  w_vec_off;
  logic [c_PW-1:0]  w_fidx;
  logic             w_unused;

  assign w_unused = ^{mstatus, mip, mie};

  always_comb begin
    w_n = '0;
    for (int i = 0; i < LANES; i++) begin
      w_n       = w_n + c_CW'(in_valid[i]);
      w_slot[i] = r_tail + c_PW'(i);
    end
  end

  // Free-space test uses the registered count only; a same-cycle retire does not help.
  assign in_ready     = ({1'b0, r_count} + (c_CW+1)'(LANES)) <= (c_CW+1)'(DEPTH);
  assign commit_valid = (r_count != '0);
  assign count        = r_count;

  always_comb begin
    w_pend             = '0;
    w_pend[NCAUSE-1:0] = mip[NCAUSE-1:0] & mie[NCAUSE-1:0];
    w_cause            = '0;
    for (int i = NCAUSE - 1; i >= 0; i--) begin
      if (w_pend[i]) w_cause = 5'(i);
    end
    if (w_pend[7])  w_cause = 5'd7;
    if (w_pend[3])  w_cause = 5'd3;
    if (w_pend[11]) w_cause = 5'd11;
  end

  assign w_gie          = (priviledge_mode == 2'd0) || (priviledge_mode == 2'd3 && mstatus[3]);
  assign trap_taken     = commit_valid && w_gie && (w_pend != '0);
  assign trap_cause     = trap_taken ? w_cause : 5'd0;
  assign redirect_valid = trap_taken;
  assign w_vec_off      = (mtvec[1:0] == 2'b01) ? XLEN'({w_cause, 2'b00}) : '0;
  assign redirect_pc    = trap_taken ? ({mtvec[XLEN-1:2], 2'b00} + w_vec_off) : '0;

  assign commit_pc   = commit_valid ? r_pc[r_head]   : '0;
  assign commit_rd   = commit_valid ? r_rd[r_head]   : '0;
  assign commit_data = commit_valid ? r_data[r_head] : '0;
  assign commit_skip = commit_valid && r_skip[r_head];
  assign commit_wen  = commit_valid && !trap_taken && r_wen[r_head];

  assign w_flush = trap_taken && commit_ready;
  assign w_deq   = commit_valid && commit_ready;
  assign w_enq   = in_ready && (w_n != '0) && !w_flush;

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    w_fidx   = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_fidx = r_head + c_PW'(j);
      if (fwd_rd != 5'd0 && r_vld[w_fidx] && r_wen[w_fidx] && r_rd[w_fidx] == fwd_rd) begin
        fwd_hit  = 1'b1;
        fwd_data = r_data[w_fidx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else if (w_flush) begin
      r_head  <= r_tail;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_deq) begin
        r_head        <= r_head + 1'b1;
        r_vld[r_head] <= 1'b0;
      end
      if (w_enq) begin
        r_tail <= r_tail + c_PW'(w_n);
        for (int i = 0; i < LANES; i++) begin
          if (in_valid[i]) r_vld[w_slot[i]] <= 1'b1;
        end
      end
      r_count <= r_count + (w_enq ? w_n : '0) - c_CW'(w_deq);
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_valid[i]) begin
          r_pc[w_slot[i]]   <= in_pc[i*XLEN +: XLEN];
          r_data[w_slot[i]] <= in_data[i*XLEN +: XLEN];
          r_rd[w_slot[i]]   <= in_rd[i*5 +: 5];
          r_wen[w_slot[i]]  <= in_wen[i];
          r_skip[w_slot[i]] <= in_skip[i];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/wb_commit_buffer.md
Name: wb_commit_buffer

Overview:
Parametrised writeback/commit stage. Accepts up to LANES completed instructions per cycle from the memory stage into an in-order buffer of DEPTH entries and retires one per cycle to the commit/difftest interface. Checks pending, enabled interrupts against the head entry, redirects to mtvec (direct or vectored) and flushes on a taken trap. Also provides a youngest-first register forwarding lookup over buffered entries.

Parameters:
LANES, 2, writeback lanes accepted per cycle (1..4)
DEPTH, 4, buffer entries; power of two, DEPTH >= LANES
XLEN, 64, data/PC/CSR width
NCAUSE, 16, interrupt cause bits examined in mip/mie (cause index 0..NCAUSE-1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  LANES  per-lane valid; lanes are packed, lane i valid implies lane i-1 valid
in_ready  out  1  buffer accepts the whole group this cycle
in_pc  in  LANES*XLEN  instruction PC per lane
in_rd  in  LANES*5  destination register
in_wen  in  LANES  register write enable
in_data  in  LANES*XLEN  writeback value
in_skip  in  LANES  difftest skip flag
priviledge_mode  in  2  current mode (0 = user, 3 = machine)
mstatus  in  XLEN  mstatus; bit 3 = MIE
mip  in  XLEN  interrupt pending
mie  in  XLEN  interrupt enable
mtvec  in  XLEN  trap vector; [1:0] = mode
commit_valid  out  1  head entry retiring this cycle
commit_ready  in  1  downstream accepts retirement
commit_pc  out  XLEN  PC of retiring entry
commit_rd  out  5  destination
commit_wen  out  1  register write; forced 0 when trap taken
commit_data  out  XLEN  write value
commit_skip  out  1  difftest skip
trap_taken  out  1  interrupt taken at head this cycle
trap_cause  out  5  cause index taken
redirect_valid  out  1  fetch redirect
redirect_pc  out  XLEN  redirect target
fwd_rd  in  5  forwarding query register
fwd_hit  out  1  query matches a buffered entry with wen=1, rd!=0
fwd_data  out  XLEN  value of youngest matching entry
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async): head = tail = 0, count = 0, all entry valid bits cleared; all outputs 0 except in_ready = 1.
- Storage: circular buffer indexed by head/tail pointers modulo DEPTH; count tracked separately so full (count == DEPTH) and empty (count == 0) are unambiguous.
- Enqueue is all-or-nothing. n = popcount(in_valid). in_ready = (DEPTH - count) >= LANES, independent of in_valid. On in_ready && n > 0, lanes 0..n-1 are written at tail..tail+n-1 (mod DEPTH) in lane order, and tail advances by n. Lane 0 is oldest.
- Commit: commit_valid = count != 0. The commit_* outputs show the head entry combinationally. On commit_valid && commit_ready, head advances by 1. Simultaneous enqueue and commit update count by n - 1. A full buffer that commits this cycle still shows in_ready = 0 (registered-count rule; no bypass).
- Write latency: an entry enqueued at edge k is presented at head no earlier than cycle k+1.
- Interrupt check (only when commit_valid):
  - pend = mip[NCAUSE-1:0] & mie[NCAUSE-1:0].
  - Globally enabled when priviledge_mode == 0, or when priviledge_mode == 3 && mstatus[3].
  - Cause priority: 11, 3, 7, then remaining bits lowest index first.
  - If enabled and pend != 0: trap_taken = 1, trap_cause = selected index, commit_wen = 0, redirect_valid = 1.
  - redirect_pc = {mtvec[XLEN-1:2], 2'b00} + (mtvec[1:0] == 1 ? 4*cause : 0).
- Trap action: when commit_ready is high, the whole buffer is flushed at the clock edge (head = tail, count = 0). Any group presented with in_ready that same cycle is discarded. When commit_ready is low, nothing changes and the trap outputs hold.
- Forwarding: search all occupied entries youngest to oldest, including the same-cycle head. Entries being enqueued this cycle are not visible. fwd_rd == 0 always gives fwd_hit = 0.
- Pointer wrap: tail + n crossing DEPTH wraps modulo; pointer arithmetic uses $clog2(DEPTH) bits.
- Reset mid-operation: all contents are dropped immediately, with no commit or redirect emitted.

Test Plan:
- Reset, then LANES=2 group {pc 0x80000000 rd5=0x11, pc 0x80000004 rd6=0x22}, commit_ready=1 -> commits on the next two cycles, in order, with the matching pc/rd/data; count goes 2,1,0.
- Fill DEPTH=4 with commit_ready=0 -> in_ready drops when count=3 (free 1 < 2); raise commit_ready -> in_ready = 1 again once count <= 2.
- Three writes to rd7 (0xA, 0xB, 0xC) buffered, fwd_rd=7 -> fwd_hit=1, fwd_data=0xC; fwd_rd=0 -> fwd_hit=0.
- Machine mode, mstatus[3]=1, mip=mie=(1<<7)|(1<<11), mtvec=0x1001 -> trap_cause=11, redirect_pc=0x102C, commit_wen=0, buffer empty the next cycle.
- Same as previous, but mstatus[3]=0 -> no trap, normal commit. Switch to user mode -> trap taken with mtvec direct 0x1000 -> redirect_pc=0x1000.
- Assert rst while count=3 and a trap is pending -> all outputs return to reset values asynchronously; commit_valid=0 after release.
